// File: rtl/fp_alu_pkg.sv
// Shared definitions for the FP ALU front-end: operand width, tag-id sizing
// and the in-flight tag that travels alongside the shared multiplier.
package fp_alu_pkg;

    // IEEE-754 single-precision operand/result width.
    localparam int FP_W = 32;

    // Widest requester id supported (NREQ up to 8).
    localparam int MAX_ID_W = 3;

    // Number of bits needed to name one of n requesters (at least one bit).
    function automatic int id_w(input int n);
        if (n <= 2) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

    // One stage of the in-flight tag pipeline.
    typedef struct packed {
        logic                valid;
        logic [MAX_ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/fp_mul_arbiter_chk.sv
// Simulation-only protocol checks for fp_mul_arbiter.
module fp_mul_arbiter_chk #(
    parameter int NREQ = 4
) (
    input logic            clk,
    input logic            rst,
    input logic [NREQ-1:0] arrive,
    input logic [NREQ-1:0] rsp_valid,
    input logic [NREQ-1:0] req_ready,
    input logic [NREQ-1:0] req_valid
);

    // A result must never land on a requester still holding an unread result.
    a_no_overwrite: assert property (@(posedge clk) disable iff (rst)
        (arrive & rsp_valid) == '0);

    // At most one grant per cycle.
    a_grant_onehot: assert property (@(posedge clk) disable iff (rst)
        $onehot0(req_ready));

    // A grant is only offered to a requester that is asking.
    a_grant_valid: assert property (@(posedge clk) disable iff (rst)
        (req_ready & ~req_valid) == '0);

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first eligible index at or after rr_ptr,
// wrapping modulo NREQ. The pointer itself is owned by the parent.
module rr_arbiter
    import fp_alu_pkg::*;
#(
    parameter int  NREQ = 4,
    localparam int ID_W = id_w(NREQ)
) (
    input  logic [NREQ-1:0] elig,
    input  logic [ID_W-1:0] rr_ptr,
    output logic [NREQ-1:0] grant,
    output logic [ID_W-1:0] grant_id,
    output logic            grant_valid
);

    // Scan from rr_ptr upward and take the first eligible requester.
    always_comb begin
        int idx;
        grant       = '0;
        grant_id    = '0;
        grant_valid = 1'b0;
        idx         = 0;
        for (int off = 0; off < NREQ; off++) begin
            idx = (int'(rr_ptr) + off) % NREQ;
            if (!grant_valid && elig[idx]) begin
                grant[idx]  = 1'b1;
                grant_id    = ID_W'(idx);
                grant_valid = 1'b1;
            end else begin
                // an earlier index in scan order already won, or idx is idle
            end
        end
    end

endmodule

// File: rtl/fp_mul_arbiter.sv
// Shares one registered FP multiplier among NREQ requesters. Round-robin issue,
// a tag pipeline tracks which requester owns each in-flight product, and each
// requester has a one-deep response register held until consumed.
module fp_mul_arbiter
    import fp_alu_pkg::*;
#(
    parameter int  NREQ    = 4,
    parameter int  MUL_LAT = 1,
    parameter int  FP_W    = fp_alu_pkg::FP_W,
    localparam int ID_W    = id_w(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*FP_W-1:0] req_a,
    input  logic [NREQ*FP_W-1:0] req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic [FP_W-1:0]      mul_a,
    output logic [FP_W-1:0]      mul_b,
    input  logic [FP_W-1:0]      mul_res,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [NREQ*FP_W-1:0] rsp_data,
    input  logic [NREQ-1:0]      rsp_ready
);

    logic [NREQ-1:0]      busy_r;
    logic [NREQ-1:0]      rsp_valid_r;
    logic [NREQ*FP_W-1:0] rsp_data_r;
    logic [ID_W-1:0]      rr_ptr_r;
    tag_t                 tag_r [MUL_LAT];

    logic [NREQ-1:0]      elig_s;
    logic [NREQ-1:0]      grant_s;
    logic [ID_W-1:0]      grant_id_s;
    logic                 grant_valid_s;
    logic [NREQ-1:0]      rsp_hs_s;
    logic [NREQ-1:0]      arrive_s;
    tag_t                 tag_out_s;

    // Busy requesters sit out arbitration until their response is taken.
    assign elig_s   = req_valid & ~busy_r;
    assign rsp_hs_s = rsp_valid_r & rsp_ready;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .elig        (elig_s),
        .rr_ptr      (rr_ptr_r),
        .grant       (grant_s),
        .grant_id    (grant_id_s),
        .grant_valid (grant_valid_s)
    );

    assign req_ready = grant_s;
    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = rsp_data_r;

    // Steer the granted operands to the multiplier; zeros when idle.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        if (grant_valid_s) begin
            mul_a = req_a[int'(grant_id_s)*FP_W +: FP_W];
            mul_b = req_b[int'(grant_id_s)*FP_W +: FP_W];
        end else begin
            mul_a = '0;
            mul_b = '0;
        end
    end

    // The last tag stage lines up with mul_res; decode it to a per-requester strobe.
    always_comb begin
        tag_out_s = tag_r[MUL_LAT-1];
        arrive_s  = '0;
        for (int i = 0; i < NREQ; i++) begin
            arrive_s[i] = tag_out_s.valid && (tag_out_s.id == MAX_ID_W'(i));
        end
    end

    // Tag pipeline: stage 0 captures the grant on the same edge the multiplier takes operands.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < MUL_LAT; k++) begin
                tag_r[k] <= '0;
            end
        end else begin
            tag_r[0].valid <= grant_valid_s;
            tag_r[0].id    <= MAX_ID_W'(grant_id_s);
            for (int k = 1; k < MUL_LAT; k++) begin
                tag_r[k] <= tag_r[k-1];
            end
        end
    end

    // Arbitration pointer, busy flags and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_r    <= '0;
            busy_r      <= '0;
            rsp_valid_r <= '0;
            rsp_data_r  <= '0;
        end else begin
            if (grant_valid_s) begin
                rr_ptr_r <= (int'(grant_id_s) == NREQ - 1) ? '0 : grant_id_s + ID_W'(1);
            end else begin
                rr_ptr_r <= rr_ptr_r;
            end
            // grant needs !busy and handshake needs busy, so they never hit the same bit
            busy_r      <= (busy_r | grant_s) & ~rsp_hs_s;
            rsp_valid_r <= (rsp_valid_r & ~rsp_hs_s) | arrive_s;
            for (int i = 0; i < NREQ; i++) begin
                if (arrive_s[i]) begin
                    rsp_data_r[i*FP_W +: FP_W] <= mul_res;
                end else begin
                    rsp_data_r[i*FP_W +: FP_W] <= rsp_data_r[i*FP_W +: FP_W];
                end
            end
        end
    end

    fp_mul_arbiter_chk #(.NREQ(NREQ)) u_chk (
        .clk       (clk),
        .rst       (rst),
        .arrive    (arrive_s),
        .rsp_valid (rsp_valid_r),
        .req_ready (req_ready),
        .req_valid (req_valid)
    );

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Bench for fp_mul_arbiter: directed scenarios followed by random traffic,
// checked against a per-requester transaction model and a behavioural multiplier.
module tb_fp_mul_arbiter;

    localparam int NREQ    = 4;
    localparam int MUL_LAT = 1;
    localparam int FP_W    = 32;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*FP_W-1:0] req_a;
    logic [NREQ*FP_W-1:0] req_b;
    logic [NREQ-1:0]      req_ready;
    logic [FP_W-1:0]      mul_a;
    logic [FP_W-1:0]      mul_b;
    logic [FP_W-1:0]      mul_res;
    logic [NREQ-1:0]      rsp_valid;
    logic [NREQ*FP_W-1:0] rsp_data;
    logic [NREQ-1:0]      rsp_ready;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: per requester 0=idle, 1=in multiplier, 2=holding result.
    int          st    [NREQ];
    int          lat   [NREQ];
    logic [31:0] res_m [NREQ];
    int          ptr_m;
    int          exp_g;
    int          glog [$];

    fp_mul_arbiter #(.NREQ(NREQ), .MUL_LAT(MUL_LAT), .FP_W(FP_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_res   (mul_res),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_ready (rsp_ready)
    );

    always #5 clk = ~clk;

    // Truncating single-precision multiply for normal numbers and zero.
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        int          e;
        logic [47:0] p;
        logic [22:0] m;
        s = a[31] ^ b[31];
        if (a[30:0] == 31'd0 || b[30:0] == 31'd0) return {s, 31'd0};
        p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) begin
            m = p[46:24];
            e = e + 1;
        end else begin
            m = p[45:23];
        end
        return {s, 8'(e), m};
    endfunction

    // External multiplier with one cycle of latency.
    always_ff @(posedge clk) mul_res <= fmul(mul_a, mul_b);

    function automatic logic [31:0] rnd_fp();
        logic        s;
        logic [7:0]  e;
        logic [22:0] m;
        s = 1'($urandom_range(0, 1));
        e = 8'($urandom_range(100, 150));
        m = 23'($urandom);
        return {s, e, m};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rand_ops();
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*32 +: 32] = rnd_fp();
            req_b[i*32 +: 32] = rnd_fp();
        end
    endtask

    // One clock: check outputs against the model mid-cycle, then advance the model at the edge.
    task automatic tick();
        logic [NREQ-1:0] elig;
        logic [NREQ-1:0] eg;
        logic [NREQ-1:0] ev;
        logic [31:0]     ea;
        logic [31:0]     eb;
        int              idx;
        #3;
        exp_g = -1;
        if (!rst) begin
            for (int i = 0; i < NREQ; i++) elig[i] = req_valid[i] && (st[i] == 0);
            for (int off = 0; off < NREQ; off++) begin
                idx = (ptr_m + off) % NREQ;
                if (exp_g < 0 && elig[idx]) exp_g = idx;
            end
            eg = '0;
            ea = 32'd0;
            eb = 32'd0;
            if (exp_g >= 0) begin
                eg[exp_g] = 1'b1;
                ea = req_a[exp_g*32 +: 32];
                eb = req_b[exp_g*32 +: 32];
            end
            chk("req_ready", 32'(req_ready), 32'(eg));
            chk("mul_a", mul_a, ea);
            chk("mul_b", mul_b, eb);
            for (int i = 0; i < NREQ; i++) ev[i] = (st[i] == 2);
            chk("rsp_valid", 32'(rsp_valid), 32'(ev));
            for (int i = 0; i < NREQ; i++) begin
                if (st[i] == 2) chk("rsp_data", rsp_data[i*32 +: 32], res_m[i]);
            end
        end
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < NREQ; i++) st[i] = 0;
            ptr_m = 0;
        end else begin
            for (int i = 0; i < NREQ; i++) if (st[i] == 2 && rsp_ready[i]) st[i] = 0;
            for (int i = 0; i < NREQ; i++) begin
                if (st[i] == 1) begin
                    if (lat[i] == 0) st[i] = 2;
                    else lat[i] = lat[i] - 1;
                end
            end
            if (exp_g >= 0) begin
                st[exp_g]    = 1;
                lat[exp_g]   = MUL_LAT - 1;
                res_m[exp_g] = fmul(req_a[exp_g*32 +: 32], req_b[exp_g*32 +: 32]);
                ptr_m        = (exp_g + 1) % NREQ;
                glog.push_back(exp_g);
            end
        end
        #1;
    endtask

    initial begin
        int others;
        for (int i = 0; i < NREQ; i++) begin
            st[i] = 0; lat[i] = 0; res_m[i] = 32'd0;
        end
        ptr_m     = 0;
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = '0;
        req_a     = '0;
        req_b     = '0;

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        for (int i = 0; i < NREQ; i++) chk("rst_rsp_data", rsp_data[i*32 +: 32], 32'd0);

        // Single request: 3.0 x 2.0 on requester 0
        req_valid = 4'b0001;
        req_a[31:0] = 32'h4040_0000;
        req_b[31:0] = 32'h4000_0000;
        tick();
        req_valid = 4'b0000;
        chk("single_not_yet", 32'(rsp_valid[0]), 32'd0);
        tick();
        chk("single_valid", 32'(rsp_valid[0]), 32'd1);
        chk("single_data", rsp_data[31:0], 32'h40C0_0000);
        rsp_ready = 4'b0001;
        tick();
        rsp_ready = 4'b0000;
        chk("single_clear", 32'(rsp_valid[0]), 32'd0);

        // Zero operand on requester 3
        req_valid = 4'b1000;
        req_a[127:96] = 32'h0000_0000;
        req_b[127:96] = 32'h40A0_0000;
        tick();
        req_valid = 4'b0000;
        tick();
        chk("zero_valid", 32'(rsp_valid[3]), 32'd1);
        chk("zero_data", rsp_data[127:96], 32'h0000_0000);
        rsp_ready = 4'b1000;
        tick();
        rsp_ready = 4'b0000;

        // All four at once: 1.5 x 1.5 each, granted 0,1,2,3
        glog.delete();
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*32 +: 32] = 32'h3FC0_0000;
            req_b[i*32 +: 32] = 32'h3FC0_0000;
        end
        req_valid = 4'b1111;
        for (int k = 0; k < NREQ; k++) begin
            tick();
            if (glog.size() > 0) req_valid[glog[$]] = 1'b0;
        end
        tick();
        tick();
        chk("all4_grants", 32'(glog.size()), 32'd4);
        for (int k = 0; k < glog.size(); k++) chk("all4_order", 32'(glog[k]), 32'(k));
        chk("all4_valid", 32'(rsp_valid), 32'h0000_000F);
        for (int i = 0; i < NREQ; i++) chk("all4_data", rsp_data[i*32 +: 32], 32'h4010_0000);
        rsp_ready = 4'b1111;
        tick();
        tick();

        // Fairness: requesters 0 and 2 always asking, responses consumed at once
        glog.delete();
        req_valid = 4'b0101;
        for (int k = 0; k < 12; k++) begin
            rand_ops();
            tick();
        end
        chk("fair_count", 32'(glog.size()), 32'd8);
        for (int k = 1; k < glog.size(); k++) begin
            chk("fair_alternate", 32'(glog[k] != glog[k-1]), 32'd1);
            chk("fair_members", 32'(glog[k] == 0 || glog[k] == 2), 32'd1);
        end
        req_valid = 4'b0000;
        tick();
        tick();
        tick();

        // Backpressure: requester 1 holds its result for 10 cycles
        glog.delete();
        rsp_ready = 4'b1101;
        req_valid = 4'b0010;
        req_a[63:32] = 32'hC000_0000;
        req_b[63:32] = 32'h4080_0000;
        tick();
        for (int k = 0; k < 10; k++) begin
            rand_ops();
            req_a[63:32] = 32'hC000_0000;
            req_b[63:32] = 32'h4080_0000;
            req_valid = 4'($urandom) | 4'b0011;
            tick();
        end
        chk("bp_valid", 32'(rsp_valid[1]), 32'd1);
        chk("bp_data", rsp_data[63:32], 32'hC100_0000);
        others = 0;
        for (int k = 0; k < glog.size(); k++) if (glog[k] != 1) others++;
        chk("bp_others_served", 32'(others > 0), 32'd1);
        req_valid = 4'b0000;
        rsp_ready = 4'b1111;
        tick();
        tick();
        tick();

        // Reset one cycle after a grant to requester 0
        rsp_ready = 4'b0000;
        req_valid = 4'b0001;
        req_a[31:0] = rnd_fp();
        req_b[31:0] = rnd_fp();
        tick();
        rst = 1'b1;
        req_valid = 4'b0101;
        tick();
        rst = 1'b0;
        chk("rstmid_no_valid", 32'(rsp_valid), 32'd0);
        chk("rstmid_first_grant", 32'(req_ready), 32'h0000_0001);
        tick();
        req_valid = 4'b0000;
        chk("rstmid_still_quiet", 32'(rsp_valid), 32'd0);
        tick();
        rsp_ready = 4'b1111;
        tick();
        tick();

        // Random traffic with occasional resets
        for (int k = 0; k < 400; k++) begin
            rand_ops();
            req_valid = 4'($urandom);
            rsp_ready = 4'($urandom);
            rst       = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst       = 1'b0;
        req_valid = 4'b0000;
        rsp_ready = 4'b1111;
        tick();
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
